// File: rtl/sram_like_pkg.sv
// Package: sram_like_pkg
// Shared constants for the sram_like arbiter slice.
//  - SIZE_1B/2B/4B : encodings of the 2-bit transfer size field
//  - arb_state_t   : arbiter FSM states (ARB_IDLE, ARB_WAIT)
//  - OWNER_INST/OWNER_DATA : which requester owns the in-flight transaction
package sram_like_pkg;

    localparam logic [1:0] SIZE_1B = 2'b00;
    localparam logic [1:0] SIZE_2B = 2'b01;
    localparam logic [1:0] SIZE_4B = 2'b10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Interface: sram_like_arbiter_if
// One sram_like port: request fields flow master->slave, handshake and read
// data flow slave->master.
//  req/wr/size/addr/wdata : request (driven by master)
//  addr_ok                : request accepted (driven by slave)
//  data_ok/rdata          : response valid and read data (driven by slave)
interface sram_like_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Module: sram_arb_pick
// Combinational grant selection. Data wins by default; fetch wins when data is
// idle or when fetch has been starved for the maximum number of data grants.
//  inst_req, data_req : pending requests
//  starve_full        : starvation counter has reached its limit
//  grant_inst/data    : one-hot (or zero) grant
module sram_arb_pick (
    input  logic inst_req,
    input  logic data_req,
    input  logic starve_full,
    output logic grant_inst,
    output logic grant_data
);

    assign grant_inst = inst_req & (~data_req | starve_full);
    assign grant_data = data_req & ~grant_inst;

endmodule

// File: rtl/sram_like_arbiter.sv
// Module: sram_like_arbiter
// Shares one sram_like bus port between the fetch (inst) and memory-stage
// (data) requesters with a single outstanding transaction. Data has fixed
// priority; fetch is forced through after STARVE_MAX consecutive data grants
// while it waits. Fetch responses flushed by cancel are swallowed.
//  clk, resetn : clock, asynchronous active-low reset
//  cancel      : pipeline flush, kills the in-flight fetch response
//  inst        : fetch requester port (slave side)
//  data        : memory-stage requester port (slave side)
//  bus         : downstream port (master side)
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cancel,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  bus
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        state, state_nxt;
    logic              owner, owner_nxt;
    logic              discard, discard_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic              grant_inst, grant_data;
    logic              sel_inst;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick u_pick (
        .inst_req    (inst.req),
        .data_req    (data.req),
        .starve_full (starve_cnt == CNT_MAX),
        .grant_inst  (grant_inst),
        .grant_data  (grant_data)
    );

    // Request fields follow the grantee while idle and the owner while waiting;
    // with no grant they default to the data fields.
    assign sel_inst  = (state == ARB_IDLE) ? grant_inst : (owner == OWNER_INST);
    assign sel_addr  = sel_inst ? inst.addr  : data.addr;
    assign sel_wdata = sel_inst ? inst.wdata : data.wdata;
    assign bus.addr  = sel_addr;
    assign bus.wdata = sel_wdata;
    assign bus.wr    = sel_inst ? inst.wr   : data.wr;
    assign bus.size  = sel_inst ? inst.size : data.size;

    // Read data is broadcast; data_ok alone qualifies it.
    assign inst.rdata = bus.rdata;
    assign data.rdata = bus.rdata;

    // Next-state and handshake logic. A fetch cancelled at any point between
    // acceptance and completion is marked discarded; cancel on the completion
    // cycle itself also suppresses the response. Data transactions always complete.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        discard_nxt  = discard;
        starve_nxt   = starve_cnt;
        bus.req      = 1'b0;
        inst.addr_ok = 1'b0;
        data.addr_ok = 1'b0;
        inst.data_ok = 1'b0;
        data.data_ok = 1'b0;
        case (state)
            ARB_IDLE: begin
                bus.req      = grant_inst | grant_data;
                inst.addr_ok = grant_inst & bus.addr_ok;
                data.addr_ok = grant_data & bus.addr_ok;
                if (bus.req && bus.addr_ok) begin
                    state_nxt   = ARB_WAIT;
                    owner_nxt   = grant_inst ? OWNER_INST : OWNER_DATA;
                    discard_nxt = grant_inst & cancel;
                    if (grant_inst) begin
                        starve_nxt = '0;
                    end else if (inst.req && starve_cnt != CNT_MAX) begin
                        starve_nxt = starve_cnt + 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                if (cancel && owner == OWNER_INST) begin
                    discard_nxt = 1'b1;
                end
                if (bus.data_ok) begin
                    if (owner == OWNER_INST) begin
                        inst.data_ok = ~(discard | cancel);
                    end else begin
                        data.data_ok = 1'b1;
                    end
                    state_nxt   = ARB_IDLE;
                    discard_nxt = 1'b0;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_INST;
            discard    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            discard    <= discard_nxt;
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench: tb_sram_like_arbiter
// Directed sequence with a scoreboard of expected responses, pushed when a
// request is accepted and popped when the bench raises bus_data_ok.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    typedef struct {
        logic        is_data;
        logic        expect_ok;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic resetn;
    logic cancel;
    int   checks;
    int   failures;
    exp_t sb[$];

    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .cancel (cancel),
        .inst   (inst_if.slave),
        .data   (data_if.slave),
        .bus    (bus_if.master)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where inputs are driven.
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    task automatic setInst(input logic req, input logic [31:0] addr);
        inst_if.req   = req;
        inst_if.addr  = addr;
        inst_if.wr    = 1'b0;
        inst_if.size  = SIZE_4B;
        inst_if.wdata = 32'h0;
    endtask

    task automatic setData(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        data_if.req   = req;
        data_if.wr    = wr;
        data_if.size  = SIZE_4B;
        data_if.addr  = addr;
        data_if.wdata = wdata;
    endtask

    // Offer the bus accept this cycle and check who is granted.
    task automatic acceptAndCheck(input string tag, input logic is_data, input logic [31:0] addr);
        bus_if.addr_ok = 1'b1;
        #1;
        checkOutput({tag, "_bus_req"}, 64'(bus_if.req), 64'd1);
        checkOutput({tag, "_bus_addr"}, 64'(bus_if.addr), 64'(addr));
        checkOutput({tag, "_data_addr_ok"}, 64'(data_if.addr_ok), 64'(is_data));
        checkOutput({tag, "_inst_addr_ok"}, 64'(inst_if.addr_ok), 64'(!is_data));
        sb.push_back('{is_data: is_data, expect_ok: 1'b1, rdata: 32'h0});
    endtask

    // Raise bus_data_ok now and compare against the oldest expectation.
    task automatic respond(input string tag, input logic [31:0] rdata);
        exp_t e;
        bus_if.addr_ok = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = rdata;
        #1;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_inst_data_ok"}, 64'(inst_if.data_ok), 64'(!e.is_data && e.expect_ok));
            checkOutput({tag, "_data_data_ok"}, 64'(data_if.data_ok), 64'(e.is_data && e.expect_ok));
            if (e.expect_ok) begin
                checkOutput({tag, "_rdata"}, 64'(e.is_data ? data_if.rdata : inst_if.rdata), 64'(rdata));
            end
        end
    endtask

    task automatic busIdle();
        bus_if.addr_ok = 1'b0;
        bus_if.data_ok = 1'b0;
        bus_if.rdata   = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        cancel   = 1'b0;
        setInst(1'b0, 32'h0);
        setData(1'b0, 1'b0, 32'h0, 32'h0);
        busIdle();

        // Reset state: everything quiet.
        applyStimulus();
        #1;
        checkOutput("rst_bus_req", 64'(bus_if.req), 64'd0);
        checkOutput("rst_bus_addr", 64'(bus_if.addr), 64'd0);
        checkOutput("rst_addr_ok", 64'({inst_if.addr_ok, data_if.addr_ok}), 64'd0);
        checkOutput("rst_data_ok", 64'({inst_if.data_ok, data_if.data_ok}), 64'd0);
        applyStimulus();
        resetn = 1'b1;

        // 1: lone data store, response two cycles after acceptance.
        applyStimulus();
        setData(1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_0001);
        acceptAndCheck("t1", 1'b1, 32'h0000_1004);
        checkOutput("t1_bus_wr", 64'(bus_if.wr), 64'd1);
        checkOutput("t1_bus_size", 64'(bus_if.size), 64'(SIZE_4B));
        applyStimulus();
        setData(1'b0, 1'b0, 32'h0, 32'h0);
        busIdle();
        #1;
        checkOutput("t1_wait_bus_req", 64'(bus_if.req), 64'd0);
        checkOutput("t1_wait_data_ok", 64'(data_if.data_ok), 64'd0);
        applyStimulus();
        respond("t1", 32'h0);
        checkOutput("t1_inst_quiet", 64'({inst_if.addr_ok, inst_if.data_ok}), 64'd0);

        // 2: simultaneous requests; data first, then fetch.
        applyStimulus();
        busIdle();
        setInst(1'b1, 32'h0000_2000);
        setData(1'b1, 1'b0, 32'h0000_3000, 32'h0);
        acceptAndCheck("t2a", 1'b1, 32'h0000_3000);
        applyStimulus();
        setData(1'b0, 1'b0, 32'h0, 32'h0);
        busIdle();
        #1;
        checkOutput("t2_wait_inst_addr_ok", 64'(inst_if.addr_ok), 64'd0);
        applyStimulus();
        respond("t2a", 32'h1111_2222);
        applyStimulus();
        busIdle();
        acceptAndCheck("t2b", 1'b0, 32'h0000_2000);
        applyStimulus();
        setInst(1'b0, 32'h0);
        busIdle();
        applyStimulus();
        respond("t2b", 32'hDEAD_BEEF);

        // 3: starvation guard; four data grants, then fetch, then data again.
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            busIdle();
            setInst(1'b1, 32'h0000_4000);
            setData(1'b1, 1'b0, 32'h0000_5000 + 32'(i * 4), 32'h0);
            acceptAndCheck($sformatf("t3_%0d", i), (i != 4), (i == 4) ? 32'h0000_4000 : 32'h0000_5000 + 32'(i * 4));
            applyStimulus();
            busIdle();
            applyStimulus();
            respond($sformatf("t3_%0d", i), 32'h3300_0000 + 32'(i));
        end
        applyStimulus();
        busIdle();
        setInst(1'b0, 32'h0);
        setData(1'b0, 1'b0, 32'h0, 32'h0);

        // 4: fetch cancelled while waiting; late response is swallowed.
        applyStimulus();
        setInst(1'b1, 32'h0000_6000);
        acceptAndCheck("t4", 1'b0, 32'h0000_6000);
        applyStimulus();
        setInst(1'b0, 32'h0);
        busIdle();
        cancel = 1'b1;
        sb[sb.size()-1].expect_ok = 1'b0;
        applyStimulus();
        cancel = 1'b0;
        applyStimulus();
        applyStimulus();
        respond("t4", 32'h4444_4444);
        applyStimulus();
        busIdle();
        setData(1'b1, 1'b0, 32'h0000_6004, 32'h0);
        #1;
        checkOutput("t4_idle_bus_req", 64'(bus_if.req), 64'd1);
        setData(1'b0, 1'b0, 32'h0, 32'h0);

        // 5: cancel on the completion cycle of a data transaction.
        applyStimulus();
        setData(1'b1, 1'b1, 32'h0000_7000, 32'h7777_0000);
        acceptAndCheck("t5", 1'b1, 32'h0000_7000);
        applyStimulus();
        setData(1'b0, 1'b0, 32'h0, 32'h0);
        busIdle();
        applyStimulus();
        cancel = 1'b1;
        respond("t5", 32'h5555_5555);
        applyStimulus();
        cancel = 1'b0;
        busIdle();

        // 6: reset mid-wait, then a stray response must be ignored.
        applyStimulus();
        setInst(1'b1, 32'h0000_8000);
        acceptAndCheck("t6", 1'b0, 32'h0000_8000);
        applyStimulus();
        setInst(1'b0, 32'h0);
        busIdle();
        resetn = 1'b0;
        void'(sb.pop_front());
        applyStimulus();
        resetn = 1'b1;
        applyStimulus();
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h6666_6666;
        setData(1'b1, 1'b0, 32'h0000_9000, 32'h0);
        #1;
        checkOutput("t6_stray_data_ok", 64'({inst_if.data_ok, data_if.data_ok}), 64'd0);
        checkOutput("t6_bus_req", 64'(bus_if.req), 64'd1);
        checkOutput("t6_bus_addr", 64'(bus_if.addr), 64'h0000_9000);
        applyStimulus();
        busIdle();
        setData(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
